ads1256_avg_fifo: RTL and testbench
===================================

# ads1256_avg_fifo

Post-processing stage downstream of the ADS1256 acquisition controller. It takes each 24-bit two's-complement conversion result tagged with its channel (0/1) and averages 2^AVG_LOG2 consecutive results per channel. Each average is pushed into a per-channel FIFO. The MSP430 bus reads out the FIFOs (pop-on-read) and a status word, which replaces the single-latest-sample readout with buffered, decimated data.

## Interface
- AVG_LOG2, 2, log2 of samples per average; legal 0..6.
- DEPTH_LOG2, 8, log2 of FIFO depth per channel; legal 1..8.

- CLK_50M  in  1  system clock; all logic on rising edge.
- rst_n  in  1  one clock; reset is synchronous and active-low.
- smp_valid  in  1  one-cycle pulse, sample present; CLK_50M domain, synchronised upstream.
- smp_ch  in  1  channel of the sample; valid with smp_valid.
- smp_dat  in  24  signed conversion result; valid with smp_valid.
- datacs  in  1  MSP430 chip select for this block.
- RDdata  in  1  MSP430 read strobe; may be held many cycles.
- dataAddr  in  12  MSP430 word address.
- outrddat  out  24  registered read data.
- data_rdy  out  1  registered; 1 when either FIFO is non-empty.

## Operation
- Per channel c: accumulator acc_c is signed, 24+AVG_LOG2 bits. Sample counter n_c is AVG_LOG2 bits.
- smp_valid=1, ch=c:
  - When n_c is not at its terminal value: acc_c += sign_ext(smp_dat) and n_c++.
  - Terminal value is n_c = 2^AVG_LOG2-1: avg = (acc_c + sign_ext(smp_dat)) >>> AVG_LOG2. This is an arithmetic shift, truncating toward -inf, keeping the low 24 bits. avg is pushed to FIFO c, then acc_c=0 and n_c=0.
- AVG_LOG2=0: every sample is pushed unchanged.
- Channels are fully independent; any interleaving is legal.
- FIFO c: circular array of 2^DEPTH_LOG2 x 24, with wr/rd pointers wrapping modulo the depth. count_c is 9 bits, range 0..2^DEPTH_LOG2.
- Push when full: the average is dropped, ovf_c (sticky) is set, and pointers/count are unchanged.
- Read event: rising edge of (datacs & RDdata), detected against a registered copy rd_q. rd_q resets to 0, so a strobe held through reset release counts as one event.
- Address decode on a read event:
  - 12'h000: outrddat = head of FIFO0, then pop.
  - 12'h001: outrddat = head of FIFO1, then pop.
  - 12'h002: outrddat = status, then ovf0 and ovf1 are cleared. Status layout: [8:0] count0, [17:9] count1, [18] ovf0, [19] ovf1, [23:20] 0.
  - Any other address: outrddat = 0, with no side effect.
- Pop when empty: outrddat = 0; pointers, count and ovf are unchanged.
- Push and pop on the same channel in the same cycle:
  - Both take effect and count is unchanged.
  - If the FIFO was full, the push succeeds and ovf is not set.
  - If the FIFO was empty, the pop returns 0 and the push lands normally.
- Status read in the same cycle as an overflowing push: the status shows the pre-cycle ovf, and ovf ends set. The set wins over the clear.

## Timing
- Reset values: outrddat=0, data_rdy=0, acc=0, n=0, pointers=0, count=0, ovf=0, rd_q=0. FIFO RAM contents are not cleared.
- Reset mid-operation discards any partial averages and buffered data; the first sample after reset starts a fresh group.
- Sample at edge T: acc/n updated at T+1. On a completing sample, the FIFO write, count increment and data_rdy=1 are all visible at T+1.
- Read event sampled at edge T: outrddat valid after T+1 and held until the next read event. Pop/ovf-clear effects are visible at T+1.
- Back-to-back read events are at least 2 cycles apart, inherent to edge detection. A new event needs RDdata or datacs to deassert for at least one cycle.
- data_rdy = (count0≠0)|(count1≠0), registered from next-state counts. It deasserts at T+1 after the last pop.

## Configuration
- ADS1256_AVG_EN defined: averaging as above.
- ADS1256_AVG_EN undefined:
  - The accumulators and counters are not built.
  - Every valid sample is pushed directly, with a 1-cycle write latency.
  - AVG_LOG2 is ignored.
  - The register map and FIFO behaviour are identical.

## Test plan
- ADS1256_AVG_EN, AVG_LOG2=2, ch0 samples 0x000010, 0x000020, 0x000030, 0x000040 → count0=1 one cycle after the 4th sample; read 0x000 returns 0x000028; data_rdy then drops to 0.
- Same config, ch1 samples 0xFFFFFF ×3 then 0xFFFFFE (sum -5) → read 0x001 returns 0xFFFFFE, i.e. -2 from floor. Interleave ch0 samples between them and check ch0 is unaffected.
- DEPTH_LOG2=2, 5 averages on ch1 with no reads → status read returns 0x080800. A second status read returns 0x000800. Four pops then return the first four averages in order.
- Pop 0x000 while empty → outrddat=0, status count0=0, no pointer slip: the next pushed value reads back correctly.
- Depth 4 with FIFO0 full: push and pop in the same cycle → the oldest value is returned, count stays 4, ovf0=0, and the new value is the last one read out. Hold RDdata high for 20 cycles → exactly one pop.
- Assert rst_n=0 for 1 cycle after 3 of 4 ch0 samples → all outputs 0; 4 new samples of 0x000100 then produce exactly 0x000100.

Source files
------------

// File: rtl/ads1256_avg_fifo.sv
// ADS1256 post-processing: per-channel 2^AVG_LOG2 averaging into two FIFOs read over the MSP430 bus.
// Build option: define ADS1256_AVG_EN to enable averaging; when undefined every sample is buffered as-is.
module ads1256_avg_fifo #(
  parameter int AVG_LOG2   = 2,
  parameter int DEPTH_LOG2 = 8
) (
  input  logic        CLK_50M,
  input  logic        rst_n,
  input  logic        smp_valid,
  input  logic        smp_ch,
  input  logic [23:0] smp_dat,
  input  logic        datacs,
  input  logic        RDdata,
  input  logic [11:0] dataAddr,
  output logic [23:0] outrddat,
  output logic        data_rdy
);
  localparam int DEPTH = 1 << DEPTH_LOG2;

  if (AVG_LOG2 < 0 || AVG_LOG2 > 6) begin : g_bad_avg_log2
    $error("AVG_LOG2 must be within 0..6");
  end
  if (DEPTH_LOG2 < 1 || DEPTH_LOG2 > 8) begin : g_bad_depth_log2
    $error("DEPTH_LOG2 must be within 1..8");
  end

  logic        w_push       [2];
  logic [23:0] w_push_dat   [2];
  logic [8:0]  w_count      [2];
  logic [8:0]  w_count_next [2];
  logic        w_ovf        [2];
  logic [23:0] w_head       [2];
  logic        r_rd_q;
  logic        w_rd_ev;
  logic        w_stat_rd;

  // r_rd_q resets low, so a strobe held across reset release is seen as one new event.
  assign w_rd_ev   = datacs && RDdata && !r_rd_q;
  assign w_stat_rd = w_rd_ev && (dataAddr == 12'h002);

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_ch
      logic w_hit;
      assign w_hit = smp_valid && (smp_ch == 1'(gi));

`ifdef ADS1256_AVG_EN
      if (AVG_LOG2 == 0) begin : g_pass
        assign w_push[gi]     = w_hit;
        assign w_push_dat[gi] = smp_dat;
      end else begin : g_avg
        localparam int AW = 24 + AVG_LOG2;
        logic signed [AW-1:0]       r_acc;
        logic        [AVG_LOG2-1:0] r_n;
        logic signed [AW-1:0]       w_sum;
        logic                       w_last;

        assign w_sum  = r_acc + {{AVG_LOG2{smp_dat[23]}}, smp_dat};
        assign w_last = (r_n == {AVG_LOG2{1'b1}});
        assign w_push[gi] = w_hit && w_last;
        // Dropping the low bits of the signed sum is an arithmetic shift (floor).
        assign w_push_dat[gi] = w_sum[AVG_LOG2 +: 24];

        always_ff @(posedge CLK_50M) begin
          if (!rst_n) begin
            r_acc <= '0;
            r_n   <= '0;
          end else if (w_hit) begin
            if (w_last) begin
              r_acc <= '0;
              r_n   <= '0;
            end else begin
              r_acc <= w_sum;
              r_n   <= r_n + AVG_LOG2'(1);
            end
          end
        end
      end
`else
      assign w_push[gi]     = w_hit;
      assign w_push_dat[gi] = smp_dat;
`endif

      logic [23:0]           r_mem [DEPTH];
      logic [DEPTH_LOG2-1:0] r_wr_ptr;
      logic [DEPTH_LOG2-1:0] r_rd_ptr;
      logic [8:0]            r_count;
      logic                  r_ovf;
      logic                  w_full;
      logic                  w_pop;
      logic                  w_wr;

      assign w_full = (r_count == 9'(DEPTH));
      assign w_pop  = w_rd_ev && (dataAddr == 12'(gi)) && (r_count != 9'd0);
      // A simultaneous pop frees a slot, so a push into a full FIFO still lands.
      assign w_wr   = w_push[gi] && (!w_full || w_pop);
      assign w_count_next[gi] = r_count + 9'(w_wr) - 9'(w_pop);

      always_ff @(posedge CLK_50M) begin
        if (rst_n && w_wr) begin
          r_mem[r_wr_ptr] <= w_push_dat[gi];
        end
      end

      always_ff @(posedge CLK_50M) begin
        if (!rst_n) begin
          r_wr_ptr <= '0;
          r_rd_ptr <= '0;
          r_count  <= '0;
          r_ovf    <= 1'b0;
        end else begin
          if (w_wr) begin
            r_wr_ptr <= r_wr_ptr + DEPTH_LOG2'(1);
          end
          if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + DEPTH_LOG2'(1);
          end
          r_count <= w_count_next[gi];
          if (w_push[gi] && w_full && !w_pop) begin
            r_ovf <= 1'b1;
          end else if (w_stat_rd) begin
            r_ovf <= 1'b0;
          end
        end
      end

      assign w_count[gi] = r_count;
      assign w_ovf[gi]   = r_ovf;
      assign w_head[gi]  = r_mem[r_rd_ptr];
    end
  endgenerate

  always_ff @(posedge CLK_50M) begin
    if (!rst_n) begin
      r_rd_q   <= 1'b0;
      outrddat <= 24'h0;
      data_rdy <= 1'b0;
    end else begin
      r_rd_q   <= datacs && RDdata;
      data_rdy <= (w_count_next[0] != 9'd0) || (w_count_next[1] != 9'd0);
      if (w_rd_ev) begin
        case (dataAddr)
          12'h000: outrddat <= (w_count[0] != 9'd0) ? w_head[0] : 24'h0;
          12'h001: outrddat <= (w_count[1] != 9'd0) ? w_head[1] : 24'h0;
          12'h002: outrddat <= {4'h0, w_ovf[1], w_ovf[0], w_count[1], w_count[0]};
          default: outrddat <= 24'h0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ads1256_avg_fifo.sv
// Scoreboard bench for ads1256_avg_fifo (AVG_LOG2=2, depth 4); follows the ADS1256_AVG_EN build option.
module tb_ads1256_avg_fifo;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        smp_valid = 1'b0;
  logic        smp_ch = 1'b0;
  logic [23:0] smp_dat = 24'h0;
  logic        datacs = 1'b0;
  logic        RDdata = 1'b0;
  logic [11:0] dataAddr = 12'h0;
  logic [23:0] outrddat;
  logic        data_rdy;

  int n_cmp = 0;
  int n_fail = 0;

  typedef struct {
    string       nm;
    logic [23:0] v;
  } exp_t;
  exp_t exp_q[$];

  ads1256_avg_fifo #(.AVG_LOG2(2), .DEPTH_LOG2(2)) dut (
    .CLK_50M (clk),
    .rst_n   (rst_n),
    .smp_valid(smp_valid),
    .smp_ch  (smp_ch),
    .smp_dat (smp_dat),
    .datacs  (datacs),
    .RDdata  (RDdata),
    .dataAddr(dataAddr),
    .outrddat(outrddat),
    .data_rdy(data_rdy)
  );

  always #10 clk = ~clk;

  task automatic chk(input string nm, input logic [23:0] act, input logic [23:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %06h expected %06h", nm, act, exp);
    end else begin
      $display("ok   %s: %06h", nm, act);
    end
  endtask

  // Monitor: detects bus read events independently and checks the read data one cycle later.
  logic mon_rdq = 1'b0, mon_ev = 1'b0, mon_ev2 = 1'b0;
  always @(posedge clk) begin
    mon_ev  <= rst_n && datacs && RDdata && !mon_rdq;
    mon_rdq <= rst_n && datacs && RDdata;
    mon_ev2 <= mon_ev;
  end
  always @(negedge clk) begin
    if (mon_ev2) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_read: got %06h required no read event", outrddat);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk(e.nm, outrddat, e.v);
      end
    end
  end

  task automatic put(input logic ch, input logic [23:0] d);
    @(negedge clk);
    smp_valid = 1'b1; smp_ch = ch; smp_dat = d;
    @(negedge clk);
    smp_valid = 1'b0;
  endtask

  // One FIFO entry of value v: a full group of equal samples when averaging.
  task automatic put_avg(input logic ch, input logic [23:0] v);
`ifdef ADS1256_AVG_EN
    repeat (4) put(ch, v);
`else
    put(ch, v);
`endif
  endtask

  task automatic rd(input string nm, input logic [11:0] a, input logic [23:0] exp);
    exp_t e;
    @(negedge clk);
    dataAddr = a; datacs = 1'b1; RDdata = 1'b1;
    e.nm = nm; e.v = exp; exp_q.push_back(e);
    @(negedge clk);
    datacs = 1'b0; RDdata = 1'b0;
    @(negedge clk);
  endtask

  task automatic rd_hold(input string nm, input logic [11:0] a, input logic [23:0] exp, input int n);
    exp_t e;
    @(negedge clk);
    dataAddr = a; datacs = 1'b1; RDdata = 1'b1;
    e.nm = nm; e.v = exp; exp_q.push_back(e);
    repeat (n) @(negedge clk);
    datacs = 1'b0; RDdata = 1'b0;
    @(negedge clk);
  endtask

  // Completing push and a read event on the same clock edge.
  task automatic push_with_read(input logic ch, input logic [23:0] v, input string nm,
                                input logic [11:0] a, input logic [23:0] exp);
    exp_t e;
`ifdef ADS1256_AVG_EN
    repeat (3) put(ch, v);
`endif
    @(negedge clk);
    smp_valid = 1'b1; smp_ch = ch; smp_dat = v;
    dataAddr = a; datacs = 1'b1; RDdata = 1'b1;
    e.nm = nm; e.v = exp; exp_q.push_back(e);
    @(negedge clk);
    smp_valid = 1'b0; datacs = 1'b0; RDdata = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_outrddat", outrddat, 24'h0);
    chk("reset_data_rdy", {23'h0, data_rdy}, 24'h0);
    rst_n = 1'b1;
    @(negedge clk);

`ifdef ADS1256_AVG_EN
    put(0, 24'h000010); put(0, 24'h000020); put(0, 24'h000030); put(0, 24'h000040);
    chk("avg_data_rdy_up", {23'h0, data_rdy}, 24'h1);
    rd("avg_status_count0", 12'h002, 24'h000001);
    rd("avg_ch0_mean", 12'h000, 24'h000028);
    chk("avg_data_rdy_down", {23'h0, data_rdy}, 24'h0);
    put(1, 24'hFFFFFF); put(0, 24'h000010);
    put(1, 24'hFFFFFF); put(0, 24'h000020);
    put(1, 24'hFFFFFF); put(0, 24'h000030);
    put(1, 24'hFFFFFE);
    chk("floor_data_rdy", {23'h0, data_rdy}, 24'h1);
    put(0, 24'h000050);
    rd("floor_ch1_minus2", 12'h001, 24'hFFFFFE);
    rd("interleave_ch0", 12'h000, 24'h00002C);
    chk("interleave_data_rdy", {23'h0, data_rdy}, 24'h0);
`else
    put(0, 24'h123456); put(1, 24'hFEDCBA);
    chk("direct_data_rdy_up", {23'h0, data_rdy}, 24'h1);
    rd("direct_status", 12'h002, 24'h000201);
    rd("direct_ch0", 12'h000, 24'h123456);
    rd("direct_ch1", 12'h001, 24'hFEDCBA);
    chk("direct_data_rdy_down", {23'h0, data_rdy}, 24'h0);
`endif

    for (int i = 0; i < 5; i++) put_avg(1, 24'h000011 + 24'(i));
    rd("ovf_status", 12'h002, 24'h080800);
    rd("ovf_status_cleared", 12'h002, 24'h000800);
    for (int i = 0; i < 4; i++) rd("ovf_drain_ch1", 12'h001, 24'h000011 + 24'(i));
    chk("ovf_data_rdy_down", {23'h0, data_rdy}, 24'h0);

    rd("pop_empty", 12'h000, 24'h0);
    rd("pop_empty_status", 12'h002, 24'h0);
    put_avg(0, 24'h0000AB);
    rd("after_empty_pop", 12'h000, 24'h0000AB);

    put_avg(0, 24'h000055);
    rd("bad_addr_3", 12'h003, 24'h0);
    rd("bad_addr_fff", 12'hFFF, 24'h0);
    rd("bad_addr_no_pop", 12'h000, 24'h000055);

    for (int i = 1; i <= 4; i++) put_avg(0, 24'(i));
    push_with_read(0, 24'h000005, "full_push_pop", 12'h000, 24'h000001);
    rd("full_push_pop_status", 12'h002, 24'h000004);
    for (int i = 2; i <= 5; i++) rd("full_drain_ch0", 12'h000, 24'(i));
    chk("full_data_rdy_down", {23'h0, data_rdy}, 24'h0);

    put_avg(0, 24'h000006); put_avg(0, 24'h000007);
    rd_hold("hold_single_pop", 12'h000, 24'h000006, 20);
    rd("hold_status", 12'h002, 24'h000001);
    rd("hold_next", 12'h000, 24'h000007);

    for (int i = 0; i < 4; i++) put_avg(0, 24'h000021 + 24'(i));
    push_with_read(0, 24'h000025, "ovf_vs_status_pre", 12'h002, 24'h000004);
    rd("ovf_vs_status_set", 12'h002, 24'h040004);
    for (int i = 0; i < 4; i++) rd("ovf_vs_status_drain", 12'h000, 24'h000021 + 24'(i));
    rd("ovf_vs_status_final", 12'h002, 24'h0);

    push_with_read(1, 24'h000031, "empty_push_pop", 12'h001, 24'h0);
    rd("empty_push_landed", 12'h001, 24'h000031);

    put_avg(0, 24'h000077); put_avg(0, 24'h000066);
    rd("pre_reset_read", 12'h000, 24'h000077);
`ifdef ADS1256_AVG_EN
    repeat (3) put(0, 24'h000999);
`endif
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    chk("midreset_outrddat", outrddat, 24'h0);
    chk("midreset_data_rdy", {23'h0, data_rdy}, 24'h0);
    put_avg(0, 24'h000100);
    rd("post_reset_group", 12'h000, 24'h000100);
    chk("post_reset_data_rdy", {23'h0, data_rdy}, 24'h0);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 24'(exp_q.size()), 24'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

endmodule
